// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready channels of serial_subtractor.
// Optional signed-overflow flag is present only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DefaultWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit combinational full subtractor: d = a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per cycle behind valid/ready channels.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned          CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]      LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             d_bit, bout_bit;
  logic             load, step, last;
  logic             in_ready, out_valid;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last = (cnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        step = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    if (load) begin
      a_sr_d = bus.a;
      b_sr_d = bus.b;
      cnt_d  = '0;
      bin_d  = 1'b0;
    end else if (step) begin
      a_sr_d    = a_sr_q >> 1;
      b_sr_d    = b_sr_q >> 1;
      // Each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
      diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
      bin_d     = bout_bit;
      cnt_d     = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      cnt_q     <= '0;
      bin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_sr_q;
  assign bus.borrow    = bin_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (load) begin
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
    end else if (step && last) begin
      // d_bit is the final difference MSB in the last shift cycle.
      ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing A − B over WIDTH cycles, LSB first, using a single-bit full-subtractor cell and a registered borrow chain. It is the sequential inverse counterpart to the team's combinational ripple adder. It sits behind a valid/ready operand interface and presents the difference and borrow-out on a valid/ready result interface, trading latency for one-bit datapath area.

## Interface
- WIDTH, 4, operand and difference width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- borrow  output  1  unsigned borrow-out (1 when a < b)
- ovf  output  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, the block loads a and b into shift registers, clears the borrow flop and the bit counter, and moves to SHIFT.
- SHIFT: in_ready=0, out_valid=0. Each cycle processes bit i = a_sr[0], b_sr[0]:
  - d = a^b^bin
  - bout = (~a&b) | (~(a^b)&bin)
  - d shifts into diff_sr MSB, a_sr/b_sr shift right, and the borrow flop takes bout.
  - The counter increments. After the WIDTH-th bit the FSM moves to DONE.
- DONE: out_valid=1. diff, borrow and ovf are held stable. On out_ready the FSM returns to IDLE.
- in_valid is ignored outside IDLE. a/b need only be stable in the handshake cycle.
- diff and borrow are driven directly from the registers and are meaningful only while out_valid=1. In IDLE they retain the last result. During SHIFT they are in flux.
- Arithmetic is unsigned modulo 2^WIDTH. borrow is the final borrow flop value.

## Timing
- Reset (asserted asynchronously, released synchronously to clk by the system) sets:
  - state=IDLE
  - in_ready=1 (after reset release), out_valid=0
  - diff=0, borrow=0, ovf=0
  - all shift registers, the counter and the borrow flop to 0
- Reset asserted mid-SHIFT or in DONE aborts the operation. No result is emitted.
- Latency: operand handshake at edge t0 → out_valid high after edge t0+WIDTH (WIDTH SHIFT cycles).
- Result handshake at edge t1 → IDLE; in_ready high in the cycle after t1.
- Minimum initiation interval is WIDTH+2 cycles. No overlap of input acceptance with DONE.
- out_ready held low keeps DONE indefinitely, with outputs unchanged.
- The counter width is clog2(WIDTH+1). The terminal count is WIDTH−1 during the last SHIFT cycle. There is no wrap.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists.
  - The sign bits of a and b are captured at load.
  - ovf = (a_msb≠b_msb) && (diff_msb≠a_msb), registered at the SHIFT→DONE transition and held through DONE.
- Not defined:
  - No ovf port.
  - No sign-capture flops.
  - Other behaviour is identical.

## Structure
- Shared package serial_sub_pkg holds:
  - the state enum type (IDLE, SHIFT, DONE)
  - the default WIDTH constant
- Sub-module full_subtractor (inputs a, b, bin; outputs d, bout) is purely combinational. It is instantiated once in the datapath.
- The FSM, counter and shift registers live in serial_subtractor.

## Test plan
- WIDTH=4, a=5, b=3 → after 4 SHIFT cycles, out_valid=1, diff=2, borrow=0.
- a=3, b=5 → diff=14, borrow=1. With SERIAL_SUB_OVF_EN, a=7, b=15 → diff=8, borrow=1, ovf=1. With a=5, b=3 → ovf=0.
- out_ready low for 5 cycles in DONE → out_valid, diff and borrow stable throughout. in_valid pulses during SHIFT/DONE are ignored. The next operation starts only after return to IDLE.
- rst_n low during SHIFT cycle 2 → outputs reset to 0 and state=IDLE. A subsequent a=9, b=9 → diff=0, borrow=0.
- Back-to-back: a=0, b=1 (→ diff=15, borrow=1) then a=15, b=0 (→ diff=15, borrow=0), with out_ready=1 constant → second out_valid exactly WIDTH+2 cycles after the first.
